// File: rtl/lcd_pipe_pkg.sv
// Shared types and colours for the LCD compositor: mode encodings, pixel-source
// tags carried down the output pipe, source FSM states and grey expansion.
package lcd_pipe_pkg;
    typedef enum logic [1:0] {
        MODE_DUAL = 2'd0,
        MODE_RAW  = 2'd1,
        MODE_PROC = 2'd2,
        MODE_TEST = 2'd3
    } mode_e;

    typedef enum logic [2:0] {PK_BG, PK_ROM, PK_FIFO, PK_UDF, PK_TEST} pix_kind_e;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} src_state_e;

    localparam logic [23:0] COL_WHITE = 24'hFFFFFF;
    localparam logic [23:0] COL_BLACK = 24'h000000;
    localparam logic [23:0] COL_RED   = 24'hFF0000;

    function automatic logic [23:0] grey2rgb(input logic [7:0] g);
        return {3{g}};
    endfunction
endpackage

// File: rtl/lcd_pipe_if.sv
// Stream link between the compositor (master) and the external processing chain (slave).
interface lcd_pipe_if #(parameter int W = 8);
    logic         src_ready;
    logic         src_valid;
    logic         src_sof;
    logic [W-1:0] src_data;
    logic         proc_valid;
    logic [W-1:0] proc_data;

    modport master (input src_ready, proc_valid, proc_data,
                    output src_valid, src_sof, src_data);
    modport slave  (output src_ready, proc_valid, proc_data,
                    input src_valid, src_sof, src_data);
endinterface

// File: rtl/lcd_pipe_pix_fifo.sv
// Synchronous FIFO with flush; read data is the head entry, shown combinationally.
module pix_fifo #(
    parameter int   W     = 8,
    parameter int   DEPTH = 1024,
    localparam int  PW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty,
    output logic [PW:0]  count
);
    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic         wr_ok, rd_ok;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign full    = count == (PW+1)'(DEPTH);
    assign empty   = count == '0;
    assign rd_ok   = rd_en && !empty;
    // a full FIFO still takes a write when the same cycle pops
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign rd_data = mem[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
            if (rd_ok) rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !flush) mem[wr_ptr_q[PW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/lcd_pipe_display.sv
// LCD compositor: raw ROM image in the left window, FIFO-buffered chain output in the
// right window; ROM is time-shared between display reads and credit-driven streaming.
module lcd_pipe_display import lcd_pipe_pkg::*; #(
    parameter int          W          = 8,
    parameter int          AW         = 16,
    parameter int          PIC_W      = 250,
    parameter int          PIC_H      = 250,
    parameter int          SHRINK     = 8,
    parameter int          X0         = 10,
    parameter int          Y0         = 10,
    parameter int          X_GAP      = 300,
    parameter int          FIFO_DEPTH = 1024,
    parameter logic [23:0] BG         = 24'hFFFFFF,
    parameter logic [23:0] UDF_COLOR  = 24'hFF0000
) (
    input  logic          lcd_pclk,
    input  logic          rst_n,
    input  logic [10:0]   pixel_xpos,
    input  logic [10:0]   pixel_ypos,
    input  logic [1:0]    mode,
    input  logic          clr_flags,
    output logic [AW-1:0] rom_addr,
    input  logic [W-1:0]  rom_rd_data,
    lcd_pipe_if.master    ch,
    output logic [23:0]   pixel_data,
    output logic          ovf_flag,
    output logic          udf_flag
);
    localparam int N_PIX = PIC_W * PIC_H;
    localparam int PW    = $clog2(FIFO_DEPTH);

    logic [31:0] xw, yw;
    logic        fs, in_l, in_r, disp_hit, pop_req, issue;
    mode_e       mode_q, mode_d;
    src_state_e  st_q, st_d;
    logic [31:0] src_cnt_q, src_cnt_d;
    logic        src_valid_q, src_valid_d, src_sof_q, src_sof_d;
    pix_kind_e   kind_q, kind_d;
    logic [W-1:0] fdata_q, fdata_d;
    logic        tbit_q, tbit_d;
    logic [23:0] pixel_q, pixel_d;
    logic        ovf_q, ovf_d, udf_q, udf_d;
    logic [W-1:0] fifo_rd_data;
    logic        fifo_full, fifo_empty, fifo_has;
    logic [PW:0] fifo_cnt;

    assign xw   = {21'd0, pixel_xpos};
    assign yw   = {21'd0, pixel_ypos};
    assign fs   = (pixel_xpos == 11'd0) && (pixel_ypos == 11'd0);
    assign in_l = xw >= 32'(X0) && xw < 32'(X0 + PIC_W) && yw >= 32'(Y0) && yw < 32'(Y0 + PIC_H);
    assign in_r = xw >= 32'(X0 + X_GAP) && xw < 32'(X0 + X_GAP + PIC_W - SHRINK) &&
                  yw >= 32'(Y0) && yw < 32'(Y0 + PIC_H - SHRINK);

    assign disp_hit = in_l && (mode_q == MODE_DUAL || mode_q == MODE_RAW);
    assign pop_req  = in_r && (mode_q == MODE_DUAL || mode_q == MODE_PROC);
    // the fs cycle only restarts the stream; the first issue follows it
    assign issue    = st_q == S_STREAM && ch.src_ready && !disp_hit && mode_q != MODE_TEST && !fs;
    assign rom_addr = disp_hit ? AW'((yw - 32'(Y0)) * 32'(PIC_W) + (xw - 32'(X0)))
                               : AW'(src_cnt_q);
    assign fifo_has = fifo_cnt != '0;

    pix_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (lcd_pclk),
        .rst_n   (rst_n),
        .flush   (fs),
        .wr_en   (ch.proc_valid),
        .wr_data (ch.proc_data),
        .rd_en   (pop_req),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_cnt)
    );

    always_comb begin
        st_d        = st_q;
        src_cnt_d   = src_cnt_q;
        mode_d      = mode_q;
        src_valid_d = issue;
        src_sof_d   = issue && src_cnt_q == '0;
        if (fs) begin
            st_d      = S_STREAM;
            src_cnt_d = '0;
            mode_d    = mode_e'(mode);
        end else if (issue) begin
            src_cnt_d = src_cnt_q + 32'd1;
            if (src_cnt_q == 32'(N_PIX - 1)) st_d = S_DONE;
        end
    end

    // stage 1 tags the coordinate; stage 2 resolves the colour once ROM data lands
    always_comb begin
        kind_d  = PK_BG;
        tbit_d  = pixel_xpos[3] ^ pixel_ypos[3];
        fdata_d = fifo_rd_data;
        if (mode_q == MODE_TEST) begin
            if (in_l || in_r) kind_d = PK_TEST;
        end else if (disp_hit) begin
            kind_d = PK_ROM;
        end else if (pop_req) begin
            kind_d = fifo_has ? PK_FIFO : PK_UDF;
        end
        case (kind_q)
            PK_ROM:  pixel_d = grey2rgb(rom_rd_data[W-1 -: 8]);
            PK_FIFO: pixel_d = grey2rgb(fdata_q[W-1 -: 8]);
            PK_UDF:  pixel_d = UDF_COLOR;
            PK_TEST: pixel_d = tbit_q ? COL_WHITE : COL_BLACK;
            default: pixel_d = BG;
        endcase
        ovf_d = clr_flags ? 1'b0 : (ovf_q | (ch.proc_valid && fifo_full && !pop_req));
        udf_d = clr_flags ? 1'b0 : (udf_q | (pop_req && fifo_empty));
    end

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= S_IDLE;
            src_cnt_q   <= '0;
            mode_q      <= MODE_DUAL;
            src_valid_q <= 1'b0;
            src_sof_q   <= 1'b0;
            kind_q      <= PK_BG;
            fdata_q     <= '0;
            tbit_q      <= 1'b0;
            pixel_q     <= BG;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            st_q        <= st_d;
            src_cnt_q   <= src_cnt_d;
            mode_q      <= mode_d;
            src_valid_q <= src_valid_d;
            src_sof_q   <= src_sof_d;
            kind_q      <= kind_d;
            fdata_q     <= fdata_d;
            tbit_q      <= tbit_d;
            pixel_q     <= pixel_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    assign ch.src_valid = src_valid_q;
    assign ch.src_sof   = src_sof_q;
    assign ch.src_data  = src_valid_q ? rom_rd_data : '0;
    assign pixel_data   = pixel_q;
    assign ovf_flag     = ovf_q;
    assign udf_flag     = udf_q;
endmodule
